// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared EEPROM geometry, reader states and test-pattern function
package eeprom_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int PAGE_BYTES = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_HOLD,
        ST_RECOVER
    } reader_state_t;

    // Writer's pattern: a 0..PAGE_BYTES-1 ramp repeating on every page.
    function automatic logic [DATA_W-1:0] expected_byte(input logic [ADDR_W-1:0] a);
        return DATA_W'(a[$clog2(PAGE_BYTES)-1:0]);
    endfunction
endpackage

// File: rtl/eeprom_pattern_check.sv
// rtl/eeprom_pattern_check.sv - compares read bytes to the writer pattern and tracks errors
module eeprom_pattern_check
    import eeprom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              check,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    output logic [17:0]       mismatch_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err
);
    logic miss;

    assign miss = check && (data != expected_byte(addr));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mismatch_cnt   <= '0;
            first_err_addr <= '0;
            err            <= 1'b0;
        end else if (miss) begin
            if (mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + 18'd1;
            end
            if (!err) begin
                first_err_addr <= addr;
                err            <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/eeprom_reader.sv
// rtl/eeprom_reader.sv - sequential EEPROM read burst streamed out on a valid/ready port
module eeprom_reader
    import eeprom_pkg::*;
#(
    parameter int ACCESS_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr,
    output logic              nce,
    output logic              noe,
    output logic              nwe,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [17:0]       mismatch_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err
);
    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] REC_LAST = 4'(RECOVERY_CYCLES - 1);

    reader_state_t     state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] remain, remain_d;
    logic              verify_q, verify_d;
    logic              abort_pend, abort_pend_d;
    logic [ADDR_W-1:0] addr_d, rd_addr_d;
    logic [DATA_W-1:0] rd_data_d;
    logic              nce_d, noe_d, rd_valid_d, busy_d, done_d, aborted_d;
    logic              clear, check;

    assign nwe = 1'b1;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        remain_d     = remain;
        verify_d     = verify_q;
        abort_pend_d = abort_pend;
        addr_d       = addr;
        nce_d        = nce;
        noe_d        = noe;
        rd_data_d    = rd_data;
        rd_addr_d    = rd_addr;
        rd_valid_d   = rd_valid;
        busy_d       = busy;
        done_d       = 1'b0;
        aborted_d    = aborted;
        clear        = 1'b0;
        check        = 1'b0;

        if ((state == ST_ACCESS || state == ST_HOLD) && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear        = 1'b1;
                    verify_d     = verify_en;
                    remain_d     = len_m1;
                    abort_pend_d = 1'b0;
                    aborted_d    = 1'b0;
                    addr_d       = start_addr;
                    nce_d        = 1'b0;
                    noe_d        = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == ACC_LAST) begin
                    rd_data_d  = data_i;
                    rd_addr_d  = addr;
                    rd_valid_d = 1'b1;
                    check      = verify_q;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    cnt_d      = '0;
                    if (remain == '0 || abort_pend_d) begin
                        nce_d = 1'b1;
                        noe_d = 1'b1;
                        // With no float time required, finish straight from the handshake.
                        if (RECOVERY_CYCLES == 0) begin
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            aborted_d = abort_pend_d;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_RECOVER;
                        end
                    end else begin
                        addr_d   = addr + 1'b1;
                        remain_d = remain - 1'b1;
                        state_d  = ST_ACCESS;
                    end
                end
            end
            ST_RECOVER: begin
                if (cnt == REC_LAST) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    aborted_d = abort_pend;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            remain     <= '0;
            verify_q   <= 1'b0;
            abort_pend <= 1'b0;
            addr       <= '0;
            nce        <= 1'b1;
            noe        <= 1'b1;
            rd_data    <= '0;
            rd_addr    <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            remain     <= remain_d;
            verify_q   <= verify_d;
            abort_pend <= abort_pend_d;
            addr       <= addr_d;
            nce        <= nce_d;
            noe        <= noe_d;
            rd_data    <= rd_data_d;
            rd_addr    <= rd_addr_d;
            rd_valid   <= rd_valid_d;
            busy       <= busy_d;
            done       <= done_d;
            aborted    <= aborted_d;
        end
    end

    eeprom_pattern_check u_check (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .check          (check),
        .data           (data_i),
        .addr           (addr),
        .mismatch_cnt   (mismatch_cnt),
        .first_err_addr (first_err_addr),
        .err            (err)
    );
endmodule

// File: tb/tb_eeprom_reader.sv
// tb/tb_eeprom_reader.sv - directed scoreboard bench for eeprom_reader
module tb_eeprom_reader;
    localparam int ACC = 2;
    localparam int REC = 1;

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] start_addr = '0;
    logic [16:0] len_m1 = '0;
    logic        verify_en = 1'b0;
    logic        abort = 1'b0;
    logic        rd_ready = 1'b0;
    logic        corrupt_en = 1'b0;
    logic [7:0]  data_i;
    logic [16:0] addr, rd_addr, first_err_addr;
    logic [7:0]  rd_data;
    logic [17:0] mismatch_cnt;
    logic        nce, noe, nwe, rd_valid, busy, done, aborted, err;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    exp_t sb[$];

    eeprom_reader #(.ACCESS_CYCLES(ACC), .RECOVERY_CYCLES(REC)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len_m1(len_m1),
        .verify_en(verify_en), .abort(abort), .data_i(data_i), .addr(addr), .nce(nce),
        .noe(noe), .nwe(nwe), .rd_data(rd_data), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .busy(busy), .done(done), .aborted(aborted),
        .mismatch_cnt(mismatch_cnt), .first_err_addr(first_err_addr), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dev_byte(input logic [16:0] a, input logic bad);
        if (bad && (a == 17'h00085 || a == 17'h00090)) return 8'hFF;
        return {1'b0, a[6:0]};
    endfunction

    assign data_i = dev_byte(addr, corrupt_en);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [16:0] sa, input logic [16:0] lm1, input logic ver,
                         input int n_exp);
        exp_t e;
        logic [16:0] a;
        a = sa;
        for (int i = 0; i < n_exp; i++) begin
            e.a = a;
            e.d = dev_byte(a, corrupt_en);
            sb.push_back(e);
            a = a + 17'd1;
        end
        start_addr = sa;
        len_m1 = lm1;
        verify_en = ver;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!rd_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", 32'(rd_valid), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: pops the scoreboard on every handshake and watches done.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (rd_valid && rd_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                compared++;
                assert (sb.size() != 0) else begin
                    mismatched++;
                    $error("FAIL sb_underflow: observed=byte at 0x%0h expected=none", rd_addr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(e.a));
                    chk("rd_data", 32'(rd_data), 32'(e.d));
                end
                chk("nwe_high", 32'(nwe), 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("nce_at_done", 32'(nce), 1);
                chk("noe_at_done", 32'(noe), 1);
                chk("busy_at_done", 32'(busy), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hs0, dc0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_nce", 32'(nce), 1);
        chk("rst_noe", 32'(noe), 1);
        chk("rst_nwe", 32'(nwe), 1);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("rst_first_err", 32'(first_err_addr), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic 4-byte burst with verify
        rd_ready = 1'b1;
        hs0 = hs_cnt;
        dc0 = done_cnt;
        issue(17'h00000, 17'd3, 1'b1, 4);
        @(negedge clk);
        chk("c1_busy", 32'(busy), 1);
        chk("c1_nce", 32'(nce), 0);
        chk("c1_noe", 32'(noe), 0);
        chk("c1_addr", 32'(addr), 0);
        lat = 1;
        while (!rd_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("first_valid_latency", 32'(lat), ACC + 1);
        wait_done(100);
        chk("t1_bytes", 32'(hs_cnt - hs0), 4);
        chk("t1_done_pulses", 32'(done_cnt - dc0), 1);
        chk("t1_done_gap", 32'(done_cyc - last_hs_cyc), REC + 1);
        chk("t1_done_low", 32'(done), 0);
        chk("t1_err", 32'(err), 0);
        chk("t1_mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("t1_sb_empty", 32'(sb.size()), 0);

        // 2: address wrap at top of device
        hs0 = hs_cnt;
        issue(17'h1FFFE, 17'd3, 1'b1, 4);
        wait_done(100);
        chk("t2_bytes", 32'(hs_cnt - hs0), 4);
        chk("t2_err", 32'(err), 0);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // 3: two corrupted bytes in a full page
        corrupt_en = 1'b1;
        hs0 = hs_cnt;
        issue(17'h00080, 17'd127, 1'b1, 128);
        wait_done(1000);
        chk("t3_bytes", 32'(hs_cnt - hs0), 128);
        chk("t3_mismatch_cnt", 32'(mismatch_cnt), 2);
        chk("t3_first_err", 32'(first_err_addr), 32'h85);
        chk("t3_err", 32'(err), 1);

        // 4: back-pressure on the 2nd byte, verify off over a corrupt byte
        rd_ready = 1'b0;
        hs0 = hs_cnt;
        issue(17'h00084, 17'd3, 1'b0, 4);
        chk("t4_mismatch_cleared", 32'(mismatch_cnt), 0);
        wait_valid(50);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rd_valid), 1);
            chk("t4_hold_data", 32'(rd_data), 32'hFF);
            chk("t4_hold_rd_addr", 32'(rd_addr), 32'h85);
            chk("t4_hold_addr", 32'(addr), 32'h85);
            chk("t4_hold_noe", 32'(noe), 0);
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_done(100);
        corrupt_en = 1'b0;
        chk("t4_bytes", 32'(hs_cnt - hs0), 4);
        chk("t4_mismatch_cnt", 32'(mismatch_cnt), 0);
        chk("t4_err", 32'(err), 0);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // 5: abort during ACCESS of byte 2, plus a start while busy
        hs0 = hs_cnt;
        dc0 = done_cnt;
        issue(17'h00200, 17'd15, 1'b1, 2);
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start_addr = 17'h00300;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        chk("t5_bytes", 32'(hs_cnt - hs0), 2);
        chk("t5_done_pulses", 32'(done_cnt - dc0), 1);
        chk("t5_aborted", 32'(aborted), 1);
        chk("t5_sb_empty", 32'(sb.size()), 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t5_idle_busy", 32'(busy), 0);
        chk("t5_idle_nce", 32'(nce), 1);
        chk("t5_no_restart", 32'(hs_cnt - hs0), 2);

        // 6: reset while holding a byte
        rd_ready = 1'b0;
        issue(17'h00040, 17'd7, 1'b1, 8);
        wait_valid(50);
        chk("t6_aborted_cleared", 32'(aborted), 0);
        @(posedge clk); #1;
        dc0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_nce", 32'(nce), 1);
        chk("t6_noe", 32'(noe), 1);
        chk("t6_rd_valid", 32'(rd_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("t6_no_done", 32'(done_cnt - dc0), 0);
        chk("t6_idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
